// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Bus initiator between the core's load/store unit and a word-wide data RAM.
//   Byte, half and word accesses at any byte address become word-only RAM
//   cycles. A sub-word store reads the word, merges the new bytes and writes it
//   back. A load reads the word(s), aligns the data, then sign- or zero-extends
//   it. An access that crosses a word boundary touches two consecutive words.
//   The word index wraps from the last word to word 0.
//
//   Optional feature: define MISALIGN_TRAP_EN to reject misaligned accesses
//   instead of splitting them. A half at an odd address, or a word at a
//   non-zero offset, then completes at once with err=1 and no RAM cycle.
//
// Ports
//   clk, reset_n            clock (rising edge) and asynchronous active-low reset
//   req                     request strobe, sampled only while idle
//   req_we                  1 = store, 0 = load
//   req_addr                byte address
//   req_bhw                 access size code (SL_BYTE/SL_HALF/SL_WORD), other codes = word
//   req_unsigned            loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata               store data, right-aligned
//   busy                    low only while idle
//   done                    one-cycle completion pulse
//   err                     misalignment flag, valid with done
//   rdata_out               result of the most recent load
//   mem_cs, mem_we          RAM chip select / write enable
//   mem_addr                RAM byte address, always word aligned
//   mem_bhw                 constant SL_WORD
//   mem_wdata               merged write word
//   mem_rdata               RAM read data (combinational)

`ifndef SL_BYTE
`define SL_BYTE 2'b00
`endif
`ifndef SL_HALF
`define SL_HALF 2'b01
`endif
`ifndef SL_WORD
`define SL_WORD 2'b10
`endif

module lsu_mem_master #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_bhw,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata_out,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_bhw,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int WI_W = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_WR0,
        S_WR1,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic            we_q, uns_q, err_q;
    logic [1:0]      off_q;
    logic [2:0]      size_q;
    logic [WI_W-1:0] w0_q, w1;
    logic [31:0]     wdata_q, buf0, buf1;
    logic [2:0]      req_size;
    logic            req_trap, span, ld_fin;
    logic [63:0]     merged, ld_pair;

    function automatic logic [2:0] size_of(input logic [1:0] bhw);
        case (bhw)
            `SL_BYTE: return 3'd1;
            `SL_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    // Shift the two-word window down to the addressed byte, keep `size`
    // bytes and extend.
    function automatic logic [31:0] load_extract(input logic [63:0] pair, input logic [1:0] off,
                                                 input logic [2:0] size, input logic uns);
        logic [31:0] lo;
        lo = 32'(pair >> {off, 3'b000});
        case (size)
            3'd1:    return {{24{~uns & lo[7]}}, lo[7:0]};
            3'd2:    return {{16{~uns & lo[15]}}, lo[15:0]};
            default: return lo;
        endcase
    endfunction

    // Replace the addressed bytes of the two-word window with store data.
    // The low word goes to w0, the high word to w1.
    function automatic logic [63:0] store_merge(input logic [63:0] pair, input logic [31:0] data,
                                                input logic [1:0] off, input logic [2:0] size);
        logic [63:0] mask;
        case (size)
            3'd1:    mask = 64'h0000_0000_0000_00FF;
            3'd2:    mask = 64'h0000_0000_0000_FFFF;
            default: mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (pair & ~mask) | (({32'h0, data} << {off, 3'b000}) & mask);
    endfunction

    assign req_size = size_of(req_bhw);

`ifdef MISALIGN_TRAP_EN
    assign req_trap = (req_size == 3'd2 && req_addr[0]) || (req_size == 3'd4 && req_addr[1:0] != 2'd0);
`else
    assign req_trap = 1'b0;
`endif

    assign span    = ({1'b0, off_q} + size_q) > 3'd4;
    assign w1      = w0_q + WI_W'(1);
    assign merged  = store_merge({buf1, buf0}, wdata_q, off_q, size_q);
    // The word being read this cycle is taken straight from the RAM so the
    // result is visible in the same cycle as done.
    assign ld_pair = (state == S_RD1) ? {mem_rdata, buf0} : {buf1, mem_rdata};
    assign ld_fin  = !we_q && ((state == S_RD0 && !span) || state == S_RD1);

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign err     = (state == S_DONE) && err_q;
    assign mem_bhw = `SL_WORD;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            off_q     <= 2'd0;
            size_q    <= 3'd0;
            w0_q      <= '0;
            wdata_q   <= '0;
            buf0      <= '0;
            buf1      <= '0;
            rdata_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_trap;
                off_q   <= req_addr[1:0];
                size_q  <= req_size;
                w0_q    <= req_addr[ADDR_W-1:2];
                wdata_q <= req_wdata;
            end
            if (state == S_RD0) buf0 <= mem_rdata;
            if (state == S_RD1) buf1 <= mem_rdata;
            if (ld_fin) rdata_out <= load_extract(ld_pair, off_q, size_q, uns_q);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (req_trap)
                        state_nxt = S_DONE;
                    else if (req_we && req_size == 3'd4 && req_addr[1:0] == 2'd0)
                        state_nxt = S_WR0;
                    else
                        state_nxt = S_RD0;
                end
            end
            S_RD0:   state_nxt = span ? S_RD1 : (we_q ? S_WR0 : S_DONE);
            S_RD1:   state_nxt = we_q ? S_WR0 : S_DONE;
            S_WR0:   state_nxt = span ? S_WR1 : S_DONE;
            S_WR1:   state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            S_RD0: begin
                mem_cs   = 1'b1;
                mem_addr = {w0_q, 2'b00};
            end
            S_RD1: begin
                mem_cs   = 1'b1;
                mem_addr = {w1, 2'b00};
            end
            S_WR0: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w0_q, 2'b00};
                mem_wdata = merged[31:0];
            end
            S_WR1: begin
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w1, 2'b00};
                mem_wdata = merged[63:32];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
`ifndef SL_BYTE
`define SL_BYTE 2'b00
`endif
`ifndef SL_HALF
`define SL_HALF 2'b01
`endif
`ifndef SL_WORD
`define SL_WORD 2'b10
`endif

module tb_lsu_mem_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [7:0]  req_addr = 8'h0;
    logic [1:0]  req_bhw = 2'b00;
    logic [31:0] req_wdata = 32'h0;
    logic        busy, done, err, mem_cs, mem_we;
    logic [31:0] rdata_out, mem_wdata, mem_rdata;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_bhw;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_bhw(req_bhw), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata_out(rdata_out),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_bhw(mem_bhw),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM attached to the DUT
    logic [31:0] ram [0:63] = '{0: 32'hAAFF72CC, 1: 32'h00000001, 63: 32'h00000276, default: 32'h0};
    assign mem_rdata = ram[mem_addr[7:2]];
    always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr[7:2]] <= mem_wdata;

    // Reference memory image kept by the model
    logic [31:0] ref_mem [0:63] = '{0: 32'hAAFF72CC, 1: 32'h00000001, 63: 32'h00000276, default: 32'h0};
    logic [31:0] last_rdata = 32'h0;

    int n_chk = 0, n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    typedef struct packed {
        logic        first;
        logic        cs;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        dn;
        logic        er;
        logic [31:0] rd;
    } cyc_t;

    cyc_t exp_mem [0:4095];
    int   wr_ptr = 0, rd_ptr = 0;

    function automatic cyc_t mk(input logic first, input logic cs, input logic we, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic dn, input logic er, input logic [31:0] rd);
        cyc_t e;
        e.first = first; e.cs = cs; e.we = we; e.addr = addr;
        e.wdata = wdata; e.dn = dn; e.er = er; e.rd = rd;
        return e;
    endfunction

    task automatic push(input cyc_t e);
        exp_mem[wr_ptr % 4096] = e;
        wr_ptr++;
    endtask

    // Request-level model: which words are read/written, what each write
    // holds, and what a load returns, built byte by byte from the memory image.
    task automatic model_req(input logic we, input logic [7:0] a, input logic [1:0] bhw,
                             input logic uns, input logic [31:0] wd, output int n);
        int size, off, nw, ba;
        int w [2];
        bit span, trap, rd;
        logic [31:0] v, nr;
        size = (bhw == `SL_BYTE) ? 1 : (bhw == `SL_HALF) ? 2 : 4;
        off  = int'(a[1:0]);
        span = (off + size) > 4;
        w[0] = int'(a[7:2]);
        w[1] = (w[0] + 1) % 64;
        nw   = span ? 2 : 1;
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (size == 2 && (off % 2) == 1) || (size == 4 && off != 0);
`endif
        nr = last_rdata;
        n  = 0;
        if (trap) begin
            push(mk(1'b1, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b1, nr));
            n++;
        end else begin
            rd = !(we && size == 4 && off == 0);
            if (rd) begin
                for (int i = 0; i < nw; i++) begin
                    push(mk(n == 0, 1'b1, 1'b0, 8'(w[i] * 4), 32'h0, 1'b0, 1'b0, nr));
                    n++;
                end
            end
            if (we) begin
                for (int k = 0; k < size; k++) begin
                    ba = (int'(a) + k) % 256;
                    ref_mem[ba / 4][8 * (ba % 4) +: 8] = wd[8 * k +: 8];
                end
                for (int i = 0; i < nw; i++) begin
                    push(mk(n == 0, 1'b1, 1'b1, 8'(w[i] * 4), ref_mem[w[i]], 1'b0, 1'b0, nr));
                    n++;
                end
            end else begin
                v = 32'h0;
                for (int k = 0; k < size; k++) begin
                    ba = (int'(a) + k) % 256;
                    v[8 * k +: 8] = ref_mem[ba / 4][8 * (ba % 4) +: 8];
                end
                if (!uns && size == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
                if (!uns && size == 2 && v[15]) v[31:16] = 16'hFFFF;
                nr = v;
            end
            push(mk(n == 0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b1, 1'b0, nr));
            n++;
        end
        last_rdata = nr;
    endtask

    // Per-cycle compare against the model's expected cycle list
    bit          chk_en = 1'b0;
    int          cyc_n = 0, obs_cs = 0, obs_we = 0, obs_lat = 0;
    logic [31:0] obs_rdata = 32'h0;
    logic        obs_err = 1'b0;

    initial begin
        cyc_t e;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (rd_ptr < wr_ptr) begin
                    e = exp_mem[rd_ptr % 4096];
                    rd_ptr++;
                    if (e.first) begin
                        cyc_n = 0; obs_cs = 0; obs_we = 0; obs_lat = 0;
                    end
                    cyc_n++;
                    chk("busy", 32'(busy), 32'd1);
                    chk("mem_cs", 32'(mem_cs), 32'(e.cs));
                    chk("mem_we", 32'(mem_we), 32'(e.we));
                    if (e.cs) chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    chk("done", 32'(done), 32'(e.dn));
                    chk("err", 32'(err), 32'(e.er));
                    chk("rdata_out", rdata_out, e.rd);
                    if (mem_cs) obs_cs++;
                    if (mem_we) obs_we++;
                    if (done) begin
                        obs_lat = cyc_n; obs_rdata = rdata_out; obs_err = err;
                    end
                end else begin
                    chk("idle busy", 32'(busy), 32'd0);
                    chk("idle done", 32'(done), 32'd0);
                    chk("idle mem_cs", 32'(mem_cs), 32'd0);
                    chk("idle rdata_out", rdata_out, last_rdata);
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [7:0] a, input logic [1:0] bhw,
                          input logic uns, input logic [31:0] wd);
        int n;
        @(negedge clk);
        #1;
        req_we = we; req_addr = a; req_bhw = bhw; req_unsigned = uns; req_wdata = wd;
        req = 1'b1;
        @(posedge clk);
        model_req(we, a, bhw, uns, wd, n);
        #1;
        // keep req high with unrelated fields while busy; it must be ignored
        req_we = 1'($urandom); req_addr = 8'($urandom); req_bhw = 2'($urandom);
        req_unsigned = 1'($urandom); req_wdata = $urandom;
        repeat (n) @(negedge clk);
        #1 req = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset rdata_out", rdata_out, 32'h0);
        chk("reset mem_cs", 32'(mem_cs), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("mem_bhw", 32'(mem_bhw), 32'(`SL_WORD));
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        do_req(1'b0, 8'h01, `SL_BYTE, 1'b0, 32'h0);
        chk("byte ld 01 s", obs_rdata, 32'h00000072);
        chk("byte ld latency", 32'(obs_lat), 32'd2);
        chk("byte ld cs cycles", 32'(obs_cs), 32'd1);
        do_req(1'b0, 8'h03, `SL_BYTE, 1'b0, 32'h0);
        chk("byte ld 03 s", obs_rdata, 32'hFFFFFFAA);
        do_req(1'b0, 8'h03, `SL_BYTE, 1'b1, 32'h0);
        chk("byte ld 03 u", obs_rdata, 32'h000000AA);

        do_req(1'b0, 8'h02, `SL_HALF, 1'b0, 32'h0);
        chk("half ld 02 s", obs_rdata, 32'hFFFFAAFF);

        do_req(1'b0, 8'h03, `SL_WORD, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("word ld 03 err", 32'(obs_err), 32'd1);
        chk("word ld 03 latency", 32'(obs_lat), 32'd1);
        chk("word ld 03 cs", 32'(obs_cs), 32'd0);
        chk("word ld 03 rdata kept", obs_rdata, 32'hFFFFAAFF);
`else
        chk("word ld 03", obs_rdata, 32'h000001AA);
        chk("word ld 03 latency", 32'(obs_lat), 32'd3);
        chk("word ld 03 cs", 32'(obs_cs), 32'd2);
        chk("word ld 03 err", 32'(obs_err), 32'd0);
`endif

        do_req(1'b1, 8'hFF, `SL_HALF, 1'b0, 32'h0000BEEF);
`ifdef MISALIGN_TRAP_EN
        chk("half st FF word63", ram[63], 32'h00000276);
        chk("half st FF word0", ram[0], 32'hAAFF72CC);
        chk("half st FF err", 32'(obs_err), 32'd1);
`else
        chk("half st FF word63", ram[63], 32'hEF000276);
        chk("half st FF word0", ram[0], 32'hAAFF72BE);
        chk("half st FF latency", 32'(obs_lat), 32'd5);
        chk("half st FF we cycles", 32'(obs_we), 32'd2);
`endif

        do_req(1'b1, 8'h00, `SL_WORD, 1'b0, 32'h12345678);
        chk("word st word0", ram[0], 32'h12345678);
        chk("word st latency", 32'(obs_lat), 32'd2);
        chk("word st cs cycles", 32'(obs_cs), 32'd1);

        do_req(1'b1, 8'h05, `SL_BYTE, 1'b0, 32'h0000005A);
        chk("byte st word1", ram[1], 32'h00005A01);
        chk("byte st we cycles", 32'(obs_we), 32'd1);
        chk("byte st latency", 32'(obs_lat), 32'd3);

        // reset in the middle of a byte store's write cycle
        chk_en = 1'b0;
        @(negedge clk);
        #1;
        req_we = 1'b1; req_addr = 8'h09; req_bhw = `SL_BYTE; req_unsigned = 1'b0;
        req_wdata = 32'h00000033; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        chk("rst-test rd cycle cs", 32'(mem_cs), 32'd1);
        chk("rst-test rd cycle we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("rst-test wr cycle we", 32'(mem_we), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst mem_we drop", 32'(mem_we), 32'd0);
        chk("rst mem_cs drop", 32'(mem_cs), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst target word kept", ram[2], 32'h0);
        chk("rst rdata_out", rdata_out, 32'h0);
        last_rdata = 32'h0;
        #1 reset_n = 1'b1;
        chk_en = 1'b1;
        do_req(1'b0, 8'h09, `SL_BYTE, 1'b1, 32'h0);
        chk("post-reset ld latency", 32'(obs_lat), 32'd2);
        chk("post-reset ld value", obs_rdata, 32'h00000000);

        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 8'hFC + 8'($urandom_range(0, 7));
            do_req(1'($urandom), ra, 2'($urandom), 1'($urandom), $urandom);
        end

        @(negedge clk);
        for (int w = 0; w < 64; w++) chk($sformatf("final ram[%0d]", w), ram[w], ref_mem[w]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
